// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module ex_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        rd_hilo,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall_req,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] acc_q, acc_d, q_q, q_d, d_q, d_d;
   logic        is_div_q, is_div_d, negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;

   logic        a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   logic [32:0] mul_sum, div_rem;
   logic        div_ge;
   logic [31:0] div_sub;
   logic [63:0] prod;
   logic [31:0] quo, rem;

   // op[0]=0 selects the signed variants
   assign a_neg = ~op[0] & rs_val[31];
   assign b_neg = ~op[0] & rt_val[31];
   assign a_abs = a_neg ? (~rs_val + 32'd1) : rs_val;
   assign b_abs = b_neg ? (~rt_val + 32'd1) : rt_val;

   // acc_q:q_q is the 64-bit working pair; shifts right for multiply, left for divide
   assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, d_q} : 33'd0);
   assign div_rem = {acc_q, q_q[31]};
   assign div_ge  = div_rem >= {1'b0, d_q};
   assign div_sub = div_rem[31:0] - d_q;

   assign prod = negq_q ? (~{acc_q, q_q} + 64'd1) : {acc_q, q_q};
   assign quo  = div0_q ? 32'hFFFF_FFFF : (negq_q ? (~q_q + 32'd1) : q_q);
   assign rem  = negr_q ? (~acc_q + 32'd1) : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      q_d      = q_q;
      d_d      = d_q;
      is_div_d = is_div_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      div0_d   = div0_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               acc_d    = '0;
               q_d      = a_abs;
               d_d      = b_abs;
               is_div_d = op[1];
               negq_d   = a_neg ^ b_neg;
               negr_d   = a_neg;
               div0_d   = op[1] & (rt_val == 32'd0);
               cnt_d    = '0;
               state_d  = CALC;
            end else if (!start) begin
               if (mthi) hi_d = rs_val;
               if (mtlo) lo_d = rs_val;
            end
         end
         CALC: begin
            if (is_div_q) begin
               acc_d = div_ge ? div_sub : div_rem[31:0];
               q_d   = {q_q[30:0], div_ge};
            end else begin
               acc_d = mul_sum[32:1];
               q_d   = {mul_sum[0], q_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FIX;
         end
         FIX: begin
            if (!flush) begin
               hi_d = is_div_q ? rem : prod[63:32];
               lo_d = is_div_q ? quo : prod[31:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         d_q      <= '0;
         is_div_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         d_q      <= d_d;
         is_div_q <= is_div_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         div0_q   <= div0_d;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIX) & ~flush;
   assign stall_req = busy & (start | rd_hilo | mthi | mtlo);
endmodule
